serial_add_ctrl: RTL and testbench

//  Bit-serial adder sequencer. Reuses a single 1-bit full-adder cell (two half_tasizan

---
 rtl/serial_add_ctrl.sv | 179 +++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder sequencer. One shared 1-bit full-adder cell
//                (two half-adders plus a carry flop) adds two WIDTH-bit
//                operands LSB first, one bit per clock, behind a start/done
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================

// Half-adder cell; two of these form the shared full adder.
module half_tasizan (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_done;

    logic               w_s1;
    logic               w_c1;
    logic               w_s;
    logic               w_c2;
    logic               w_cout;
    logic [WIDTH-1:0]   w_acc_next;

    // Shared full-adder cell built from two half-adders.
    half_tasizan u_ha0 (
        .x (r_a[0]),
        .y (r_b[0]),
        .s (w_s1),
        .c (w_c1)
    );

    half_tasizan u_ha1 (
        .x (w_s1),
        .y (r_carry),
        .s (w_s),
        .c (w_c2)
    );

    assign w_cout = w_c1 | w_c2;

    // Result shift register: the new sum bit enters at the MSB end so that
    // after WIDTH shifts the LSB computed first sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_acc_single
            assign w_acc_next = w_s;
        end else begin : g_acc_wide
            logic [WIDTH-2:0] r_acc;

            assign w_acc_next = {w_s, r_acc};

            // Holds the sum bits produced so far, upper-aligned.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_acc <= '0;
                end else if (r_state == ST_RUN) begin
                    r_acc <= w_acc_next[WIDTH-1:1];
                end
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus accept / last-bit decode.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == C_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand shifting, carry/counter update and result capture on completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == ST_RUN) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + C_ONE;
                if (w_last) begin
                    // Carry into the MSB is the carry flop before this edge.
                    r_sum  <= w_acc_next;
                    r_cout <= w_cout;
                    r_ovf  <= r_carry ^ w_cout;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Directed self-checking bench for serial_add_ctrl (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_checks;
    int n_fail;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all zero",
                     busy, done, sum, cout, ovf);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            a     = 8'hFF;
            b     = 8'hFF;
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) begin
                n_fail++;
                $display("FAIL basic_run cycle %0d: got busy=%b done=%b sum=%h, expected 1 0 00",
                         i, busy, done, sum);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1 || sum !== 8'h96 || cout !== 1'b0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected 0 1 96 0 1",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || sum !== 8'h96) begin
            n_fail++;
            $display("FAIL basic_pulse_hold: got done=%b sum=%h, expected 0 96", done, sum);
        end
    endtask

    task automatic test_carry();
        logic [7:0] va [2];
        logic [7:0] vb [2];
        logic [7:0] es [2];
        logic       ec [2];
        logic       eo [2];
        logic [7:0] prev;
        va[0] = 8'hFF; vb[0] = 8'h01; es[0] = 8'h00; ec[0] = 1'b1; eo[0] = 1'b0;
        va[1] = 8'h80; vb[1] = 8'h80; es[1] = 8'h00; ec[1] = 1'b1; eo[1] = 1'b1;
        prev = 8'h96;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            start = 1'b1;
            a     = va[v];
            b     = vb[v];
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (i == 4) begin
                    n_checks++;
                    if (busy !== 1'b1 || sum !== prev) begin
                        n_fail++;
                        $display("FAIL carry_hold vec %0d: got busy=%b sum=%h, expected 1 %h",
                                 v, busy, sum, prev);
                    end
                end
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1 || sum !== es[v] || cout !== ec[v] || ovf !== eo[v]) begin
                n_fail++;
                $display("FAIL carry_done vec %0d: got done=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
                         v, done, sum, cout, ovf, es[v], ec[v], eo[v]);
            end
            prev = es[v];
        end
    endtask

    task automatic test_start_held();
        int n_done;
        n_done = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        @(negedge clk);
        a = 8'h11;
        b = 8'h22;
        if (done === 1'b1) n_done++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                start = 1'b0;
            end
        end
        n_checks++;
        if (done !== 1'b1 || sum !== 8'h46 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL held_result: got done=%b sum=%h cout=%b ovf=%b, expected 1 46 0 0",
                     done, sum, cout, ovf);
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL held_done_count: got %0d done pulses, expected 1", n_done);
        end
        n_checks++;
        if (busy !== 1'b0 || sum !== 8'h46) begin
            n_fail++;
            $display("FAIL held_idle: got busy=%b sum=%h, expected 0 46", busy, sum);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done;
        n_done = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected 0 0 00 0 0",
                     busy, done, sum, cout, ovf);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d busy/done cycles, expected 0", n_done);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1;
        a     = 8'h05;
        b     = 8'h06;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || sum !== 8'h0B) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b sum=%h, expected 1 0b", done, sum);
        end
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 0 || i == 7) begin
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_busy cycle %0d: got busy=%b done=%b, expected 1 0",
                             i, busy, done);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h03 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b busy=%b sum=%h cout=%b ovf=%b, expected 1 0 03 0 0",
                     done, busy, sum, cout, ovf);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_carry();
        test_start_held();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
